// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO slice.
package fifo_pkg;

  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_t;

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage built from resettable rows; combinational read port.
module fifo_regfile #(
  parameter int WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int DEPTH = fifo_pkg::FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic [WIDTH-1:0] row_q;
    logic             row_we;

    assign row_we = we && (waddr == AW'(i));

    // Storage rows get rst_n tied high by the parent, so contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) row_q <= '0;
      else if (row_we) row_q <= wdata;
    end

    assign mem[i] = row_q;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_rw.sv
// Single-clock FIFO controller: request decode FSM, pointers, count and registered dout.
module fifo_sync_rw
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    data_count,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: wr_en/rd_en are sampled each rising edge with no ready back-pressure;
  // the outcome of the edge-N request shows on ack/err right after edge N.
  state_t           state, state_nxt;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             do_wr, do_rd;

  assign full  = (data_count == CW'(DEPTH));
  assign empty = (data_count == '0);

  always_comb begin
    state_nxt = NO_OP;
    if (wr_en && !rd_en)      state_nxt = full  ? WR_ERROR : WRITE;
    else if (rd_en && !wr_en) state_nxt = empty ? RD_ERROR : READ;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  // Datapath acts on the decoded next state so the result lands on the same edge.
  assign do_wr = (state_nxt == WRITE);
  assign do_rd = (state_nxt == READ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr     <= wr_ptr + 1'b1;
        data_count <= data_count + CW'(1);
      end
      if (do_rd) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_count <= data_count - CW'(1);
        dout       <= rd_data;
      end
    end
  end

  assign wr_ack = (state == WRITE);
  assign wr_err = (state == WR_ERROR);
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERROR);

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (1'b1),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
